lsu_mem_stage: RTL and testbench

- Memory-access stage directly downstream of the ALU in the npc core.
- Takes the ALU result as an effective address, plus the store data and load/store control.
- Issues one 8-byte-aligned request on a valid/ready memory port, then extracts and sign/zero-extends load data.
- Hands a writeback packet to the register-file stage over valid/ready. Non-memory ops pass the ALU result through.

---
 rtl/lsu_mem_stage.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage after the ALU.
// Takes the ALU result as an effective address and issues one 8-byte-aligned
// request on a valid/ready memory port. Load data is extracted and
// sign/zero-extended, then handed to writeback over valid/ready.
// Non-memory ops pass the ALU result through.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         op handshake from the ALU stage
//   in_is_load, in_is_store   op kind (both set => load)
//   in_funct3                 RV64 width/sign code
//   in_addr, in_wdata, in_rd  effective address / store data / dest reg
//   mem_req_*                 aligned request: we, addr, lane-shifted wdata, wmask
//   mem_rsp_valid/rdata       one-cycle read-data pulse
//   out_valid/out_ready       writeback handshake
//   out_we, out_rd, out_data  writeback packet
//   out_misalign              only with LSU_MISALIGN_TRAP_EN
//
// Optional macro LSU_MISALIGN_TRAP_EN: a load/store not aligned to its width
// skips the memory access and returns addr with out_misalign=1, out_we=0.
// Without it, bytes beyond lane 7 are silently dropped.
module lsu_mem_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_we,
  output logic [4:0]            out_rd,
  output logic [DATA_W-1:0]     out_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  out_misalign
`endif
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        load_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [4:0]  rd_q;

  logic              is_mem;
  logic              illegal;
  logic              trap;
  logic [MASK_W-1:0] base_mask;
  logic [MASK_W-1:0] st_mask;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] rsp_shift;
  logic [DATA_W-1:0] ld_data;
  logic              ld_sext;

  assign in_ready = (state == IDLE);

  // Request-side decode of the incoming op.
  always_comb begin
    is_mem  = in_is_load | in_is_store;
    // Load takes priority when both flags are set.
    illegal = in_is_load ? (in_funct3 == 3'd7) : in_funct3[2];
    case (in_funct3[1:0])
      2'd0:    base_mask = MASK_W'(8'h01);
      2'd1:    base_mask = MASK_W'(8'h03);
      2'd2:    base_mask = MASK_W'(8'h0F);
      default: base_mask = MASK_W'(8'hFF);
    endcase
    // Shifts truncate to the bus width: bytes past lane 7 are dropped.
    st_mask = base_mask << in_addr[2:0];
    st_data = in_wdata << {in_addr[2:0], 3'b000};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic [2:0] align_lo;
  always_comb begin
    case (in_funct3[1:0])
      2'd0:    align_lo = 3'b000;
      2'd1:    align_lo = 3'b001;
      2'd2:    align_lo = 3'b011;
      default: align_lo = 3'b111;
    endcase
    trap = is_mem & ~illegal & (|(in_addr[2:0] & align_lo));
  end
`else
  assign trap = 1'b0;
`endif

  // Load extraction from the captured byte offset and width code.
  always_comb begin
    rsp_shift = mem_rsp_rdata >> {off_q, 3'b000};
    ld_sext   = ~f3_q[2];
    case (f3_q[1:0])
      2'd0:    ld_data = {{(DATA_W-8){ld_sext & rsp_shift[7]}},   rsp_shift[7:0]};
      2'd1:    ld_data = {{(DATA_W-16){ld_sext & rsp_shift[15]}}, rsp_shift[15:0]};
      2'd2:    ld_data = {{(DATA_W-32){ld_sext & rsp_shift[31]}}, rsp_shift[31:0]};
      default: ld_data = rsp_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      load_q        <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_valid     <= 1'b0;
      out_we        <= 1'b0;
      out_rd        <= '0;
      out_data      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      out_misalign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            load_q <= in_is_load;
            f3_q   <= in_funct3;
            off_q  <= in_addr[2:0];
            rd_q   <= in_rd;
`ifdef LSU_MISALIGN_TRAP_EN
            out_misalign <= trap;
`endif
            if (is_mem && !illegal && !trap) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_we    <= ~in_is_load;
              mem_req_addr  <= {in_addr[ADDR_W-1:3], 3'b000};
              mem_req_wdata <= in_is_load ? '0 : st_data;
              mem_req_wmask <= in_is_load ? '0 : st_mask;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_rd    <= in_rd;
              if (trap) begin
                out_data <= DATA_W'(in_addr);
                out_we   <= 1'b0;
              end else if (is_mem) begin
                out_data <= '0;
                out_we   <= 1'b0;
              end else begin
                out_data <= DATA_W'(in_addr);
                out_we   <= (in_rd != 5'd0);
              end
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (load_q) begin
              state <= WAIT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_rd    <= rd_q;
              out_we    <= 1'b0;
              out_data  <= '0;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_rd    <= rd_q;
            out_we    <= (rd_q != 5'd0);
            out_data  <= ld_data;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_rd         (in_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_we        (out_we),
    .out_rd        (out_rd),
    .out_data      (out_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .out_misalign  (out_misalign)
`endif
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          exp_req;
    logic        exp_rwe;
    logic [63:0] exp_raddr;
    logic [63:0] exp_rwdata;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_data;
    logic        exp_we;
    int          exp_lat;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] addr,
    input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
    input int req, input logic rwe, input logic [63:0] raddr, input logic [63:0] rwdata,
    input logic [7:0] wmask, input logic [63:0] data, input logic we, input int lat,
    input logic mis);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.exp_req = req; v.exp_rwe = rwe; v.exp_raddr = raddr;
    v.exp_rwdata = rwdata; v.exp_wmask = wmask; v.exp_data = data; v.exp_we = we;
    v.exp_lat = lat; v.exp_mis = mis;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   got, reqs, pend, lat, hs;

    //                 ld st f3 addr                    wdata                  rd rdata                  req we raddr          rwdata                 wmask  data                   we lat mis
    vecs.push_back(mk(0, 0, 0, 64'h1234,              64'h0,                 5, 64'h0,                 0, 0, 64'h0,         64'h0,                 8'h00, 64'h1234,              1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 64'hABCD,              64'h0,                 0, 64'h0,                 0, 0, 64'h0,         64'h0,                 8'h00, 64'hABCD,              0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 64'h8000_0003,         64'h0,                 7, 64'h80FF_0000,         1, 0, 64'h8000_0000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1, 2, 0));
    vecs.push_back(mk(1, 0, 4, 64'h8000_0003,         64'h0,                 7, 64'h80FF_0000,         1, 0, 64'h8000_0000, 64'h0,                 8'h00, 64'h80,                1, 2, 0));
    vecs.push_back(mk(0, 1, 1, 64'h8000_0006,         64'hBEEF,              3, 64'h0,                 1, 1, 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0,                0, 1, 0));
    vecs.push_back(mk(1, 0, 3, 64'h10,                64'h0,                 1, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h10,      64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF, 1, 2, 0));
    vecs.push_back(mk(1, 0, 2, 64'h14,                64'h0,                 2, 64'h89AB_CDEF_0123_4567, 1, 0, 64'h10,      64'h0,                 8'h00, 64'hFFFF_FFFF_89AB_CDEF, 1, 2, 0));
    vecs.push_back(mk(1, 0, 6, 64'h14,                64'h0,                 2, 64'h89AB_CDEF_0123_4567, 1, 0, 64'h10,      64'h0,                 8'h00, 64'h0000_0000_89AB_CDEF, 1, 2, 0));
    vecs.push_back(mk(1, 0, 1, 64'h22,                64'h0,                 8, 64'h1111_2222_8765_3333, 1, 0, 64'h20,      64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_8765, 1, 2, 0));
    vecs.push_back(mk(1, 0, 5, 64'h26,                64'h0,                 8, 64'hF00D_0000_0000_0000, 1, 0, 64'h20,      64'h0,                 8'h00, 64'hF00D,              1, 2, 0));
    vecs.push_back(mk(1, 0, 7, 64'h40,                64'h0,                 4, 64'hFFFF,              0, 0, 64'h0,         64'h0,                 8'h00, 64'h0,                 0, 0, 0));
    vecs.push_back(mk(1, 0, 3, 64'h8,                 64'h0,                 0, 64'h55,                1, 0, 64'h8,         64'h0,                 8'h00, 64'h55,                0, 2, 0));
    vecs.push_back(mk(0, 1, 3, 64'h18,                64'hDEAD_BEEF_CAFE_F00D, 9, 64'h0,               1, 1, 64'h18,        64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0,                0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 64'h7,                 64'h12AB,              9, 64'h0,                 1, 1, 64'h0,         64'hAB00_0000_0000_0000, 8'h80, 64'h0,                0, 1, 0));
    vecs.push_back(mk(0, 1, 4, 64'h20,                64'h1,                 9, 64'h0,                 0, 0, 64'h0,         64'h0,                 8'h00, 64'h0,                 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 64'h30,                64'h77,                9, 64'hCAFE,              1, 0, 64'h30,        64'h0,                 8'h00, 64'hCAFE,              1, 2, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 1, 2, 64'h106,               64'h1122_3344,         9, 64'h0,                 0, 0, 64'h0,         64'h0,                 8'h00, 64'h106,               0, 0, 1));
    vecs.push_back(mk(1, 0, 3, 64'h5,                 64'h0,                 10, 64'h0102_0304_0506_0708, 0, 0, 64'h0,      64'h0,                 8'h00, 64'h5,                 0, 0, 1));
    vecs.push_back(mk(1, 0, 2, 64'h8000_0002,         64'h0,                 11, 64'h0,                0, 0, 64'h0,         64'h0,                 8'h00, 64'h8000_0002,         0, 0, 1));
`else
    vecs.push_back(mk(0, 1, 2, 64'h106,               64'h1122_3344,         9, 64'h0,                 1, 1, 64'h100,       64'h3344_0000_0000_0000, 8'hC0, 64'h0,                0, 1, 0));
    vecs.push_back(mk(1, 0, 3, 64'h5,                 64'h0,                 10, 64'h0102_0304_0506_0708, 1, 0, 64'h0,      64'h0,                 8'h00, 64'h0000_0000_0001_0203, 1, 2, 0));
`endif

    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
    in_addr = '0; in_wdata = '0; in_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_we", out_we, 0);
    check("rst_wmask", mem_req_wmask, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      in_valid = 1'b1; in_is_load = v.ld; in_is_store = v.st; in_funct3 = v.f3;
      in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd;
      mem_req_ready = 1'b1; out_ready = 1'b1;
      got = 0; reqs = 0; pend = 0; lat = -1;
      for (int c = 0; c < 20 && got == 0; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        if (pend != 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = v.rdata;
          pend = 0;
        end
        if (out_valid) begin
          got = 1;
          lat = c;
          check($sformatf("v%0d_out_data", i), out_data, v.exp_data);
          check($sformatf("v%0d_out_we", i), out_we, v.exp_we);
          check($sformatf("v%0d_out_rd", i), out_rd, v.rd);
`ifdef LSU_MISALIGN_TRAP_EN
          check($sformatf("v%0d_misalign", i), out_misalign, v.exp_mis);
`endif
        end else if (mem_req_valid) begin
          reqs++;
          check($sformatf("v%0d_req_we", i), mem_req_we, v.exp_rwe);
          check($sformatf("v%0d_req_addr", i), mem_req_addr, v.exp_raddr);
          check($sformatf("v%0d_req_wmask", i), mem_req_wmask, v.exp_wmask);
          if (v.exp_rwe) check($sformatf("v%0d_req_wdata", i), mem_req_wdata, v.exp_rwdata);
          if (!mem_req_we) pend = 1;
        end
      end
      check($sformatf("v%0d_out_seen", i), got, 1);
      check($sformatf("v%0d_req_count", i), reqs, v.exp_req);
      if (got != 0) check($sformatf("v%0d_latency", i), lat, v.exp_lat);
      mem_req_ready = 1'b0;
    end

    // Backpressure: request held 3 cycles, writeback held 2 cycles.
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b1; in_funct3 = 3'd2;
    in_addr = 64'h44; in_wdata = 64'hA5A5_A5A5; in_rd = 5'd12;
    mem_req_ready = 1'b0; out_ready = 1'b0; hs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("bp_req_valid_%0d", k), mem_req_valid, 1);
      check($sformatf("bp_req_addr_%0d", k), mem_req_addr, 64'h40);
      check($sformatf("bp_req_wdata_%0d", k), mem_req_wdata, 64'hA5A5_A5A5_0000_0000);
      check($sformatf("bp_req_wmask_%0d", k), mem_req_wmask, 8'hF0);
      check($sformatf("bp_req_we_%0d", k), mem_req_we, 1);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      if (k == 3) begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) hs++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (mem_req_valid) hs++;
      check($sformatf("bp_out_valid_%0d", j), out_valid, 1);
      check($sformatf("bp_out_data_%0d", j), out_data, 0);
      check($sformatf("bp_out_we_%0d", j), out_we, 0);
      check($sformatf("bp_out_rd_%0d", j), out_rd, 12);
      check($sformatf("bp_in_ready_out_%0d", j), in_ready, 0);
      if (j == 2) out_ready = 1'b1;
    end
    @(negedge clk);
    if (mem_req_valid) hs++;
    check("bp_out_released", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_request_count", hs, 1);
    mem_req_ready = 1'b0;

    // Reset while waiting for read data; the late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'd3;
    in_addr = 64'h50; in_rd = 5'd6; mem_req_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rw_req_valid", mem_req_valid, 1);
    @(negedge clk);
    check("rw_waiting_req", mem_req_valid, 0);
    check("rw_waiting_out", out_valid, 0);
    rst = 1'b1; mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rw_rst_in_ready", in_ready, 1);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h77;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rw_out_valid_%0d", k), out_valid, 0);
      check($sformatf("rw_in_ready_%0d", k), in_ready, 1);
      check($sformatf("rw_req_valid_%0d", k), mem_req_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
    in_addr = 64'h99; in_rd = 5'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("rw_after_valid", out_valid, 1);
    check("rw_after_data", out_data, 64'h99);
    check("rw_after_we", out_we, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
